// File: rtl/selector_pkg.sv
// Shared definitions for the selector value-to-index table: field width
// helpers, loader state encoding and the {value, index} entry packer that
// both the loader and the lookup use.
package selector_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_e;

  // Width of a field able to hold n distinct codes (at least one bit).
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned vw_of(input int unsigned size);
    return clog2_min1(size);
  endfunction

  function automatic int unsigned iw_of(input int unsigned k);
    return clog2_min1(k);
  endfunction

  function automatic int unsigned ew_of(input int unsigned size, input int unsigned k);
    return vw_of(size) + iw_of(k);
  endfunction

  // Value in the upper bits, slot index in the low iw bits.
  function automatic logic [31:0] pack_entry(input logic [31:0] value,
                                             input logic [31:0] index,
                                             input int unsigned iw);
    logic [31:0] mask;
    mask = (32'd1 << iw) - 32'd1;
    return (value << iw) | (index & mask);
  endfunction

endpackage

// File: rtl/selector_table_loader_if.sv
// Upstream value stream (valid/ready) feeding the selector table loader.
interface selector_table_loader_if #(
  parameter int unsigned VW = 4
) ();
  logic          in_valid;
  logic [VW-1:0] in_value;
  logic          in_ready;

  modport master (output in_valid, output in_value, input in_ready);
  modport slave  (input in_valid, input in_value, output in_ready);
endinterface

// File: rtl/selector_dup_cam.sv
// Duplicate detector: compares an offered value against the value fields of
// every occupied table slot and reports a single hit bit.
module selector_dup_cam
  import selector_pkg::*;
#(
  parameter  int unsigned SIZE = 16,
  parameter  int unsigned K    = 8,
  localparam int unsigned VW   = vw_of(SIZE),
  localparam int unsigned IW   = iw_of(K),
  localparam int unsigned EW   = VW + IW
) (
  input  logic [EW*K-1:0] table_bus,
  input  logic [IW:0]     count,
  input  logic [VW-1:0]   value,
  output logic            hit
);

  logic [K-1:0] occupied;
  logic [K-1:0] match;

  // Slots below count are occupied; a hit needs an occupied slot with equal value.
  always_comb begin
    occupied = '0;
    match    = '0;
    for (int unsigned i = 0; i < K; i++) begin
      occupied[i] = ((IW+1)'(i) < count);
      match[i]    = occupied[i] && (table_bus[i*EW+IW +: VW] == value);
    end
    hit = |match;
  end

endmodule

// File: rtl/selector_table_loader.sv
// Selector table loader: sequentially collects K values over a valid/ready
// stream and presents them as the packed {value, index} table consumed by
// the selector lookup, qualified by table_valid.
// Optional build macro SELECTOR_DUP_CHECK_EN: discard values already in the
// table and raise a sticky dup_err instead of storing them.
module selector_table_loader
  import selector_pkg::*;
#(
  parameter  int unsigned SIZE = 16,
  parameter  int unsigned K    = 8,
  localparam int unsigned VW   = vw_of(SIZE),
  localparam int unsigned IW   = iw_of(K),
  localparam int unsigned EW   = VW + IW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    clear,
  selector_table_loader_if.slave  in_if,
  output logic [EW*K-1:0]         table_bus,
  output logic                    table_valid,
  output logic [IW:0]             count,
  output logic                    dup_err
);

  state_e          state_q, state_d;
  logic [EW*K-1:0] table_q, table_d;
  logic [IW:0]     count_q, count_d;
  logic            dup_q, dup_d;
  logic            ready;
  logic            dup_hit;

`ifdef SELECTOR_DUP_CHECK_EN
  selector_dup_cam #(
    .SIZE (SIZE),
    .K    (K)
  ) u_dup_cam (
    .table_bus (table_q),
    .count     (count_q),
    .value     (in_if.in_value),
    .hit       (dup_hit)
  );
`else
  assign dup_hit = 1'b0;
`endif

  // Next-state, table write and handshake; clear has priority over start.
  always_comb begin
    state_d = state_q;
    table_d = table_q;
    count_d = count_q;
    dup_d   = dup_q;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear) begin
          table_d = '0;
          count_d = '0;
        end else if (start) begin
          state_d = LOAD;
          table_d = '0;
          count_d = '0;
          dup_d   = 1'b0;
        end
      end
      LOAD, FULL: begin
        ready = (state_q == LOAD) && !start && !clear;
        if (clear) begin
          state_d = IDLE;
          table_d = '0;
          count_d = '0;
        end else if (start) begin
          state_d = LOAD;
          table_d = '0;
          count_d = '0;
          dup_d   = 1'b0;
        end else if (ready && in_if.in_valid) begin
          if (dup_hit) begin
            // Handshake completes but the value is dropped.
            dup_d = 1'b1;
          end else begin
            for (int unsigned i = 0; i < K; i++) begin
              if (count_q == (IW+1)'(i)) begin
                table_d[i*EW +: EW] = EW'(pack_entry(32'(in_if.in_value), 32'(i), IW));
              end
            end
            count_d = count_q + 1'b1;
            if (count_q == (IW+1)'(K-1)) begin
              state_d = FULL;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        table_d = '0;
        count_d = '0;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      table_q <= '0;
      count_q <= '0;
      dup_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      table_q <= table_d;
      count_q <= count_d;
      dup_q   <= dup_d;
    end
  end

  assign in_if.in_ready = ready;
  assign table_bus      = table_q;
  assign count          = count_q;
  assign table_valid    = (state_q == FULL);
  assign dup_err        = dup_q;

endmodule

// File: tb/tb_selector_table_loader.sv
// Self-checking bench for selector_table_loader (SIZE=16, K=8).
module tb_selector_table_loader;

`ifdef SELECTOR_DUP_CHECK_EN
  localparam bit DUP = 1'b1;
`else
  localparam bit DUP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic        clear;
  logic [55:0] table_bus;
  logic        table_valid;
  logic [3:0]  count;
  logic        dup_err;

  selector_table_loader_if #(.VW(4)) bus ();

  selector_table_loader #(
    .SIZE (16),
    .K    (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .clear       (clear),
    .in_if       (bus),
    .table_bus   (table_bus),
    .table_valid (table_valid),
    .count       (count),
    .dup_err     (dup_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  // Reference model: mode 0 idle, 1 loading, 2 full; stored values in order.
  int         m_mode;
  logic [3:0] m_vals[$];
  bit         m_dup;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [55:0] model_table();
    logic [55:0] t;
    t = '0;
    for (int i = 0; i < m_vals.size(); i++)
      t = t | (56'(int'(m_vals[i]) * 8 + i) << (i * 7));
    return t;
  endfunction

  function automatic bit model_has(input logic [3:0] v);
    foreach (m_vals[i]) if (m_vals[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [6:0] entry(input logic [55:0] t, input int i);
    return t[i*7 +: 7];
  endfunction

  // Lookup consumer: OR of indices whose value field equals n.
  function automatic logic [2:0] lookup(input logic [55:0] t, input logic [3:0] n);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (t[i*7+3 +: 4] == n) r = r | 3'(i);
    return r;
  endfunction

  task automatic model_step(input bit st, input bit cl, input bit v, input logic [3:0] val);
    if (cl) begin
      m_mode = 0;
      m_vals.delete();
    end else if (st) begin
      m_mode = 1;
      m_vals.delete();
      m_dup = 1'b0;
    end else if (m_mode == 1 && v) begin
      if (DUP && model_has(val)) m_dup = 1'b1;
      else begin
        m_vals.push_back(val);
        if (m_vals.size() == 8) m_mode = 2;
      end
    end
  endtask

  task automatic check_all();
    chk("table_bus", 64'(table_bus), 64'(model_table()));
    chk("count", 64'(count), 64'(m_vals.size()));
    chk("table_valid", 64'(table_valid), 64'(m_mode == 2));
    chk("dup_err", 64'(dup_err), 64'(m_dup));
  endtask

  // One clock: drive, check in_ready before the edge, then check state after it.
  task automatic cyc(input bit st, input bit cl, input bit v, input logic [3:0] val, output bit hs);
    bit exp_rdy;
    start = st; clear = cl; bus.in_valid = v; bus.in_value = val;
    #2;
    exp_rdy = (m_mode == 1) && !st && !cl;
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    hs = v && exp_rdy;
    @(posedge clk); #1;
    model_step(st, cl, v, val);
    check_all();
  endtask

  task automatic do_reset(input bit v);
    rst = 1'b1; start = 1'b0; clear = 1'b0; bus.in_valid = v; bus.in_value = 4'd7;
    @(posedge clk); #1;
    rst = 1'b0;
    m_mode = 0; m_vals.delete(); m_dup = 1'b0;
    check_all();
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
  endtask

  typedef struct {
    string      name;
    logic [3:0] vals[8];
    bit         gap;
    logic [6:0] e0, e2, e7;
    logic [3:0] lk_n;
    logic [2:0] lk_idx;
  } vec_t;

  initial begin
    vec_t       vecs[3];
    bit         hs;
    int         idx, budget;
    bit         v;
    logic [3:0] rv;

    n_cmp = 0; n_fail = 0;
    m_mode = 0; m_dup = 1'b0;
    rst = 1'b1; start = 1'b0; clear = 1'b0; bus.in_valid = 1'b0; bus.in_value = '0;

    vecs[0] = '{"load_b2b", '{4'd5, 4'd3, 4'd9, 4'd0, 4'd15, 4'd1, 4'd7, 4'd2}, 1'b0,
                7'h28, 7'h4A, 7'h17, 4'd9, 3'd2};
    vecs[1] = '{"load_gap", '{4'd5, 4'd3, 4'd9, 4'd0, 4'd15, 4'd1, 4'd7, 4'd2}, 1'b1,
                7'h28, 7'h4A, 7'h17, 4'd9, 3'd2};
    vecs[2] = '{"load_alt", '{4'd8, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd14}, 1'b1,
                7'h40, 7'h12, 7'h77, 4'd14, 3'd7};

    @(posedge clk); #1;
    do_reset(1'b0);

    // Reset in the middle of a load.
    cyc(1, 0, 0, 0, hs);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 4'(i + 1), hs);
    chk("midload_count", 64'(count), 64'(3));
    do_reset(1'b1);
    chk("midload_table", 64'(table_bus), 64'(0));
    chk("midload_cnt0", 64'(count), 64'(0));
    chk("midload_tv", 64'(table_valid), 64'(0));
    cyc(0, 0, 1, 4'd3, hs);

    // Table-driven full loads.
    for (int t = 0; t < 3; t++) begin
      cyc(1, 0, 0, 0, hs);
      idx = 0; budget = 40; v = 1'b1;
      while (idx < 8 && budget > 0) begin
        cyc(0, 0, v, vecs[t].vals[idx], hs);
        if (hs) idx++;
        if (vecs[t].gap) v = ~v;
        budget--;
      end
      if (idx < 8) begin
        n_cmp++; n_fail++;
        $display("FAIL %s_timeout: got %0d transfers want 8", vecs[t].name, idx);
      end
      chk({vecs[t].name, "_tv"}, 64'(table_valid), 64'(1));
      chk({vecs[t].name, "_e0"}, 64'(entry(table_bus, 0)), 64'(vecs[t].e0));
      chk({vecs[t].name, "_e2"}, 64'(entry(table_bus, 2)), 64'(vecs[t].e2));
      chk({vecs[t].name, "_e7"}, 64'(entry(table_bus, 7)), 64'(vecs[t].e7));
      chk({vecs[t].name, "_cnt"}, 64'(count), 64'(8));
      chk({vecs[t].name, "_lookup"}, 64'(lookup(table_bus, vecs[t].lk_n)), 64'(vecs[t].lk_idx));
      cyc(0, 0, 1, 4'd11, hs);
      chk({vecs[t].name, "_hold_rdy"}, 64'(bus.in_ready), 64'(0));
      chk({vecs[t].name, "_hold_cnt"}, 64'(count), 64'(8));
    end

    // Restart from FULL, then start+clear together returns to IDLE.
    cyc(1, 0, 1, 4'd5, hs);
    chk("restart_table", 64'(table_bus), 64'(0));
    chk("restart_cnt", 64'(count), 64'(0));
    chk("restart_tv", 64'(table_valid), 64'(0));
    start = 1'b0; clear = 1'b0; bus.in_valid = 1'b0; #1;
    chk("restart_rdy", 64'(bus.in_ready), 64'(1));
    cyc(0, 0, 1, 4'd10, hs);
    cyc(1, 1, 1, 4'd3, hs);
    cyc(0, 0, 1, 4'd3, hs);
    chk("startclr_rdy", 64'(bus.in_ready), 64'(0));
    chk("startclr_cnt", 64'(count), 64'(0));

    // Duplicate handling: load 4,4,6.
    cyc(1, 0, 0, 0, hs);
    cyc(0, 0, 1, 4'd4, hs);
    cyc(0, 0, 1, 4'd4, hs);
    chk("dup_hs", 64'(hs), 64'(1));
    cyc(0, 0, 1, 4'd6, hs);
`ifdef SELECTOR_DUP_CHECK_EN
    chk("dup_e0", 64'(entry(table_bus, 0)), 64'(7'h20));
    chk("dup_e1", 64'(entry(table_bus, 1)), 64'(7'h31));
    chk("dup_e2", 64'(entry(table_bus, 2)), 64'(0));
    chk("dup_cnt", 64'(count), 64'(2));
    chk("dup_flag", 64'(dup_err), 64'(1));
    cyc(0, 1, 0, 0, hs);
    chk("dup_held", 64'(dup_err), 64'(1));
`else
    chk("dup_e0", 64'(entry(table_bus, 0)), 64'(7'h20));
    chk("dup_e1", 64'(entry(table_bus, 1)), 64'(7'h21));
    chk("dup_e2", 64'(entry(table_bus, 2)), 64'(7'h32));
    chk("dup_cnt", 64'(count), 64'(3));
    chk("dup_flag", 64'(dup_err), 64'(0));
    cyc(0, 1, 0, 0, hs);
`endif
    cyc(1, 0, 0, 0, hs);
    chk("dup_clr", 64'(dup_err), 64'(0));

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rv = 4'($urandom_range(0, 15));
      cyc($urandom_range(0, 99) < 5, $urandom_range(0, 99) < 3,
          $urandom_range(0, 99) < 65, rv, hs);
      if ($urandom_range(0, 199) == 0) do_reset($urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/selector_table_loader.md
Name: selector_table_loader

Overview:
- Write-side counterpart of the value-to-index lookup (`Selector`).
- Sequentially loads K (value, index) entries over a valid/ready stream.
- Presents them as the packed table bus that the lookup consumes, with a table_valid qualifier.
- Sits between the input-capture front end and the lookup stage of the sorting datapath.

Parameters:
- SIZE, 16, value range; value field width VW = $clog2(SIZE).
- K, 8, number of table entries; index field width IW = $clog2(K); entry width EW = VW + IW.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse: clear table, begin a load.
- clear  in  1  single-cycle pulse: drop table, return to IDLE.
- in_valid  in  1  upstream has a value.
- in_value  in  VW  value to store.
- in_ready  out  1  loader accepts in_value this cycle.
- table_bus  out  EW*K  packed table. Entry i is at bits [i*EW +: EW]. The upper VW bits hold the value; the lower IW bits hold index i.
- table_valid  out  1  all K entries loaded; table_bus stable.
- count  out  IW+1  number of entries loaded so far (0..K).
- dup_err  out  1  sticky duplicate-value flag (see Optional Feature).

Behaviour:
- Reset (rst=1 at clock edge):
  - state=IDLE; table_bus all zeros; count=0.
  - table_valid=0; dup_err=0; in_ready=0.
  - rst dominates start, clear and in_valid.
- States: IDLE, LOAD, FULL.
  - IDLE: in_ready=0, table_valid=0. start -> LOAD; in the same edge table_bus is zeroed, count=0, dup_err=0.
  - LOAD: in_ready = !start && !clear (combinational). A transfer occurs when in_valid && in_ready.
  - On a transfer: entry[count] <= {in_value, count[IW-1:0]}, then count <= count+1.
  - Transfer when count==K-1: the next state is FULL; table_valid=1 on that edge.
  - Latency: table_valid rises 1 cycle after the K-th handshake cycle; table_bus is final in the same cycle.
  - FULL: in_ready=0; table_valid=1; table_bus and count (=K) held.
- Exits from LOAD/FULL:
  - start in LOAD or FULL: restart. Table is zeroed, count=0, dup_err cleared, state LOAD, table_valid=0.
  - clear in LOAD or FULL: state IDLE, table zeroed, count=0, table_valid=0. dup_err is held until the next start or rst.
  - start and clear asserted together: clear wins.
  - start in IDLE with in_valid=1: no transfer in that cycle, because in_ready=0 in IDLE.
- Unloaded slots always read as zero.
- Index field always equals the slot number.
- The value field is stored unmodified; no range check, since VW bits cover 0..SIZE-1 exactly when SIZE is a power of two.
- Duplicates without the feature: accepted and stored. Downstream lookup ORs the matching indices; loader does not flag them. dup_err is tied to 0.
- in_valid=1 while in_ready=0: no state change; upstream must hold its data.

Optional Feature:
- Macro: SELECTOR_DUP_CHECK_EN.
- Defined:
  - Each offered in_value is compared against the value fields of slots 0..count-1.
  - On a match, the handshake still completes (in_ready unchanged) but the entry is discarded: count is not incremented and the table is unchanged.
  - dup_err is set and stays set until start or rst.
  - Loading continues until K distinct values are stored.
- Undefined: no comparators are built; every transfer is stored; dup_err=0.

Decomposition:
- Shared package selector_pkg:
  - width helper functions for VW/IW/EW;
  - state enum {IDLE, LOAD, FULL};
  - entry-pack function {value, index} used by both the loader and the lookup.
- One sub-module: selector_dup_cam.
  - K parallel comparators plus occupancy mask.
  - Outputs a single hit bit.
  - Instantiated only under SELECTOR_DUP_CHECK_EN.

Test Plan:
- Reset mid-LOAD (after 3 transfers) -> next cycle: table_bus=0, count=0, state IDLE, in_ready=0, table_valid=0.
- start, then values 5,3,9,0,15,1,7,2 on consecutive cycles with in_valid=1 -> table_valid=1 one cycle after the 8th transfer.
  - Entry0={5,0}, entry2={9,2}, entry7={2,7}; count=8; in_ready=0 afterwards.
- Same load with in_valid toggling every other cycle -> identical table; count increments only on handshake cycles.
- In FULL, pulse start -> table zeroed, count=0, table_valid=0, in_ready=1 next cycle; pulse start+clear together -> IDLE.
- Load 4,4,6: without the macro -> entries {4,0},{4,1},{6,2}, dup_err=0.
  - With SELECTOR_DUP_CHECK_EN -> entries {4,0},{6,1}, count=2, dup_err=1 until next start.
- Loaded table fed to the lookup with N=9 -> lookup returns index 2; N=4 before table_valid -> no checking required.
